switch_debouncer: RTL and testbench

Conditions the board's raw slide-switch inputs before they reach the switches PIO slave. Each bit is synchronised into `clk` through two flops, then debounced by a per-bit consecutive-agreement counter. Only changes that hold steady for a full window update the clean vector. That vector drives the PIO `in_port`; per-bit rise/fall pulses are provided for future edge-capture or IRQ logic.

---
 rtl/switch_debouncer_pkg.sv | 12 +
 rtl/debounce_bit.sv | 57 +++++
 rtl/switch_debouncer.sv | 38 +++
 tb/tb_switch_debouncer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Project timing constants shared by the switch conditioning logic.
package switch_debouncer_pkg;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned SW_DEBOUNCE_MS = 10;

  // Counter width able to hold cycles-1 without wrapping; never zero.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, consecutive-agreement counter, stable level and edge pulses.
// Latency: stable/pulse update DEBOUNCE_CYCLES+1 edges after the input settles; no backpressure.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;

  // Any cycle where sync2 agrees with the stable level restarts qualification.
  always_comb begin
    cnt_nxt    = '0;
    stable_nxt = sw_stable;
    if (sync2 != sw_stable) begin
      if (cnt == CNT_MAX) begin
        stable_nxt = sync2;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      sw_stable <= 1'b0;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync1     <= sw_raw;
      sync2     <= sync1;
      cnt       <= cnt_nxt;
      sw_stable <= stable_nxt;
      sw_rise   <= stable_nxt & ~sw_stable;
      sw_fall   <= ~stable_nxt & sw_stable;
      busy      <= (cnt_nxt != '0) || (sync2 != stable_nxt);
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw slide switches into a clean level vector plus per-bit rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+1 edges from a settled input to sw_stable; no backpressure.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter  int unsigned WIDTH           = 8,
  parameter  int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * SW_DEBOUNCE_MS,
  localparam int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             busy
);

  logic [WIDTH-1:0] busy_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .sw_raw   (sw_raw[i]),
      .sw_stable(sw_stable[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .busy     (busy_bits[i])
    );
  end

  assign busy = |busy_bits;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4; expected pulses are queued and checked by a monitor.
module tb_switch_debouncer;

  localparam int unsigned W  = 8;
  localparam int unsigned DC = 4;

  typedef struct {
    int unsigned edge_n;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stable;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = 8'hFF;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         busy;

  int unsigned  edge_cnt = 0;
  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  exp_t         exp_q[$];
  logic [31:0]  cnt_mon [W];

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_raw   (sw_raw),
    .sw_stable(sw_stable),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  for (genvar gi = 0; gi < W; gi++) begin : g_mon
    assign cnt_mon[gi] = 32'(dut.g_bit[gi].u_bit.cnt);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge right after sw_raw/reset_n changed: the next edge is edge 0.
  task automatic expect_pulse(input int unsigned delay, input logic [W-1:0] r,
                              input logic [W-1:0] f, input logic [W-1:0] s);
    exp_t e;
    e.edge_n = edge_cnt + 1 + delay;
    e.rise   = r;
    e.fall   = f;
    e.stable = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    logic bound_ok;
    check("rise_and_fall_disjoint", 32'(sw_rise & sw_fall), 32'h0);
    bound_ok = 1'b1;
    for (int i = 0; i < W; i++) if (cnt_mon[i] > DC - 1) bound_ok = 1'b0;
    check("counter_bound", 32'(bound_ok), 32'h1);
    if ((sw_rise | sw_fall) != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({sw_rise, sw_fall}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge",   edge_cnt,        e.edge_n);
        check("pulse_rise",   32'(sw_rise),    32'(e.rise));
        check("pulse_fall",   32'(sw_fall),    32'(e.fall));
        check("pulse_stable", 32'(sw_stable),  32'(e.stable));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all switches high: everything stays cleared.
    step(3);
    check("reset_stable", 32'(sw_stable), 32'h0);
    check("reset_rise",   32'(sw_rise),   32'h0);
    check("reset_fall",   32'(sw_fall),   32'h0);
    check("reset_busy",   32'(busy),      32'h0);
    reset_n = 1'b1;
    expect_pulse(1 + DC, 8'hFF, 8'h00, 8'hFF);
    step(8);
    check("post_reset_stable", 32'(sw_stable), 32'hFF);

    // Return to all-low, then a clean single-bit step with busy profile.
    sw_raw = 8'h00;
    expect_pulse(1 + DC, 8'h00, 8'hFF, 8'h00);
    step(8);
    sw_raw = 8'h01;
    expect_pulse(1 + DC, 8'h01, 8'h00, 8'h01);
    for (int k = 0; k <= 6; k++) begin
      step(1);
      check($sformatf("busy_edge%0d", k), 32'(busy), 32'((k >= 2 && k <= 4) ? 1 : 0));
    end
    step(2);

    // Bit 3 bounces in 2-cycle segments before settling high.
    sw_raw[3] = 1'b1; step(2);
    sw_raw[3] = 1'b0; step(2);
    sw_raw[3] = 1'b1; step(2);
    sw_raw[3] = 1'b0; step(2);
    check("bounce_no_change", 32'(sw_stable), 32'h01);
    sw_raw[3] = 1'b1;
    expect_pulse(1 + DC, 8'h08, 8'h00, 8'h09);
    step(8);

    // Bit 0 falls, bit 7 rises two cycles later: pulses two edges apart.
    sw_raw = 8'h08;
    expect_pulse(1 + DC, 8'h00, 8'h01, 8'h08);
    step(2);
    sw_raw = 8'h88;
    expect_pulse(1 + DC, 8'h80, 8'h00, 8'h88);
    step(10);

    // Simultaneous changes on several bits pulse in the same cycle.
    sw_raw = 8'h86;
    expect_pulse(1 + DC, 8'h06, 8'h08, 8'h86);
    step(8);

    // Reset during qualification abandons the pending change.
    sw_raw = 8'h00;
    expect_pulse(1 + DC, 8'h00, 8'h86, 8'h00);
    step(8);
    sw_raw = 8'h10;
    step(3);
    reset_n = 1'b0;
    step(1);
    check("midq_reset_busy",   32'(busy),      32'h0);
    check("midq_reset_stable", 32'(sw_stable), 32'h0);
    reset_n = 1'b1;
    expect_pulse(1 + DC, 8'h10, 8'h00, 8'h10);
    step(10);
    check("final_stable", 32'(sw_stable), 32'h10);
    check("final_busy",   32'(busy),      32'h0);

    check("pending_expectations", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
